// File: rtl/uart_param_if.sv
// Signal bundle between the UART and its surroundings: master = bus/pad side, slave = UART.
`timescale 1ns / 1ps

interface uart_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 rx;
    logic                 tx;
    logic [DATA_BITS-1:0] dintx;
    logic                 newd;
    logic                 parity_odd;
    logic                 busytx;
    logic                 donetx;
    logic [DATA_BITS-1:0] doutrx;
    logic                 donerx;
    logic                 frame_err;
    logic                 parity_err;

    modport master (
        output rx, dintx, newd, parity_odd,
        input  tx, busytx, donetx, doutrx, donerx, frame_err, parity_err
    );

    modport slave (
        input  rx, dintx, newd, parity_odd,
        output tx, busytx, donetx, doutrx, donerx, frame_err, parity_err
    );
endinterface

// File: rtl/uart_param_top.sv
// Parametrised full-duplex UART with independent TX and RX state machines.
// Define UART_PARITY_EN to add a parity bit to both directions.
`timescale 1ns / 1ps

module uart_param_top #(
    parameter int unsigned CLK_FREQ  = 1000000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input logic         clk,
    input logic         rst,
    uart_param_if.slave bus
);
    localparam int unsigned BitCycles  = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HalfCycles = BitCycles / 2;
    localparam int unsigned StopCycles = STOP_BITS * BitCycles;
    localparam int unsigned CntW       = $clog2(StopCycles + 1);
    localparam int unsigned BitW       = $clog2(DATA_BITS);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
`ifdef UART_PARITY_EN
    localparam logic [2:0] StParity = 3'd3;
`endif
    localparam logic [2:0] StStop   = 3'd4;

    logic [2:0]           tx_state_q, tx_state_d;
    logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
    logic [BitW-1:0]      tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_q, tx_d, busy_q, busy_d, donetx_q, donetx_d;
    logic                 tx_bit_end;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    assign tx_bit_end = (tx_cnt_q == CntW'(BitCycles - 1));

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CntW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        donetx_d   = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            StIdle: begin
                tx_cnt_d = '0;
                // The cycle that carries donetx must not accept a new word.
                if (bus.newd && !donetx_q) begin
                    tx_state_d = StStart;
                    tx_shift_d = bus.dintx;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
`ifdef UART_PARITY_EN
                    tx_par_d   = ^bus.dintx ^ bus.parity_odd;
`endif
                end
            end
            StStart: begin
                if (tx_bit_end) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = StData;
                    tx_d       = tx_shift_q[0];
                end
            end
            StData: begin
                if (tx_bit_end) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == BitW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                        tx_state_d = StParity;
                        tx_d       = tx_par_q;
`else
                        tx_state_d = StStop;
                        tx_d       = 1'b1;
`endif
                    end else begin
                        tx_bit_d   = tx_bit_q + BitW'(1);
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            StParity: begin
                if (tx_bit_end) begin
                    tx_cnt_d   = '0;
                    tx_state_d = StStop;
                    tx_d       = 1'b1;
                end
            end
`endif
            StStop: begin
                if (tx_cnt_q == CntW'(StopCycles - 1)) begin
                    tx_cnt_d   = '0;
                    tx_state_d = StIdle;
                    busy_d     = 1'b0;
                    donetx_d   = 1'b1;
                end
            end
            default: begin
                tx_state_d = StIdle;
                tx_cnt_d   = '0;
                tx_d       = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= StIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            donetx_q   <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            donetx_q   <= donetx_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    logic [2:0]           rx_state_q, rx_state_d;
    logic [CntW-1:0]      rx_cnt_q, rx_cnt_d;
    logic [BitW-1:0]      rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, doutrx_q, doutrx_d;
    logic                 donerx_q, donerx_d, frame_err_q, frame_err_d;
    logic                 rx_bit_end;
`ifdef UART_PARITY_EN
    logic                 rx_par_q, rx_par_d, parity_err_q, parity_err_d;
`endif

    assign rx_bit_end = (rx_cnt_q == CntW'(BitCycles - 1));

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q + CntW'(1);
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        doutrx_d    = doutrx_q;
        donerx_d    = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_d     = rx_par_q;
        parity_err_d = 1'b0;
`endif
        case (rx_state_q)
            StIdle: begin
                rx_cnt_d = '0;
                // The edge-detect cycle already counts towards the start-bit midpoint.
                if (!rx_s2_q && rx_prev_q) begin
                    rx_state_d = StStart;
                    rx_cnt_d   = CntW'(1);
                end
            end
            StStart: begin
                if (rx_cnt_q == CntW'(HalfCycles - 1)) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? StIdle : StData;
                end
            end
            StData: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == BitW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                        rx_state_d = StParity;
`else
                        rx_state_d = StStop;
`endif
                    end else begin
                        rx_bit_d = rx_bit_q + BitW'(1);
                    end
                end
            end
`ifdef UART_PARITY_EN
            StParity: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = rx_s2_q;
                    rx_state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (rx_bit_end) begin
                    rx_cnt_d     = '0;
                    rx_state_d   = StIdle;
                    doutrx_d     = rx_shift_q;
                    donerx_d     = 1'b1;
                    frame_err_d  = !rx_s2_q;
`ifdef UART_PARITY_EN
                    parity_err_d = rx_par_q ^ (^rx_shift_q) ^ bus.parity_odd;
`endif
                end
            end
            default: begin
                rx_state_d = StIdle;
                rx_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= StIdle;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            doutrx_q     <= '0;
            donerx_q     <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_q     <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_s1_q      <= bus.rx;
            rx_s2_q      <= rx_s1_q;
            rx_prev_q    <= rx_s2_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            doutrx_q     <= doutrx_d;
            donerx_q     <= donerx_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_PARITY_EN
            rx_par_q     <= rx_par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.tx        = tx_q;
    assign bus.busytx    = busy_q;
    assign bus.donetx    = donetx_q;
    assign bus.doutrx    = doutrx_q;
    assign bus.donerx    = donerx_q;
    assign bus.frame_err = frame_err_q;
`ifdef UART_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_param_top.sv
// Directed bench for uart_param_top: an 8-bit 1-stop instance (loopback or driven rx)
// and a 7-bit 2-stop instance in loopback.
`timescale 1ns / 1ps

module tb_uart_param_top;
    localparam int Bc   = 104;
    localparam int Half = 52;
`ifdef UART_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int F8     = (1 + 8 + P + 1) * Bc;
    localparam int F7     = (1 + 7 + P + 2) * Bc;
    localparam int RxLat8 = 2 + Half + (8 + P + 1) * Bc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic loop8 = 1'b0;
    logic rx_drv = 1'b1;

    always #5 clk = ~clk;

    uart_param_if #(.DATA_BITS(8)) u8_if ();
    uart_param_if #(.DATA_BITS(7)) u7_if ();

    assign u8_if.rx = loop8 ? u8_if.tx : rx_drv;
    assign u7_if.rx = u7_if.tx;

    uart_param_top #(
        .CLK_FREQ (1000000),
        .BAUD_RATE(9600),
        .DATA_BITS(8),
        .STOP_BITS(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(u8_if.slave)
    );

    uart_param_top #(
        .CLK_FREQ (1000000),
        .BAUD_RATE(9600),
        .DATA_BITS(7),
        .STOP_BITS(2)
    ) dut7 (
        .clk(clk),
        .rst(rst),
        .bus(u7_if.slave)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Event log sampled on the falling edge, away from the DUT's active edge.
    int ncyc = 0;
    int tx8_done = 0, tx8_cyc = 0, rx8_cnt = 0, rx8_cyc = 0;
    int tx7_done = 0, tx7_cyc = 0, rx7_cnt = 0, busy7 = 0, high7 = 0;
    logic [7:0] rx8_dout = '0;
    logic [6:0] rx7_dout = '0;
    logic rx8_ferr = 1'b0, rx8_perr = 1'b0;

    always @(negedge clk) begin
        ncyc++;
        if (u8_if.donetx) begin
            tx8_done++;
            tx8_cyc = ncyc;
        end
        if (u8_if.donerx) begin
            rx8_cnt++;
            rx8_cyc  = ncyc;
            rx8_dout = u8_if.doutrx;
            rx8_ferr = u8_if.frame_err;
            rx8_perr = u8_if.parity_err;
        end
        if (u7_if.donetx) begin
            tx7_done++;
            tx7_cyc = ncyc;
        end
        if (u7_if.busytx) begin
            busy7++;
            if (u7_if.tx) high7++;
        end
        if (u7_if.donerx) begin
            rx7_cnt++;
            rx7_dout = u7_if.doutrx;
        end
    end

    function automatic int count_of(input int sel);
        case (sel)
            0:       return tx8_done;
            1:       return rx8_cnt;
            2:       return tx7_done;
            default: return rx7_cnt;
        endcase
    endfunction

    task automatic wait_event(input int sel, input int prev, input string tag);
        int i = 0;
        while (count_of(sel) == prev && i < 3000) begin
            @(negedge clk);
            #1;
            i++;
        end
        check_eq(tag, count_of(sel), prev + 1);
    endtask

    function automatic logic [11:0] frame8(input logic [7:0] d, input logic odd);
        logic [11:0] f;
        f      = '0;
        f[8:1] = d;
        if (P == 1) begin
            f[9]  = ^d ^ odd;
            f[10] = 1'b1;
        end else begin
            f[9] = 1'b1;
        end
        return f;
    endfunction

    // Sends one word on the 8-bit instance and samples tx mid-bit for start..first stop.
    task automatic send8(input logic [7:0] data, input logic inject, output int acc_cyc,
                         output logic [11:0] cap);
        @(negedge clk);
        u8_if.dintx = data;
        u8_if.newd  = 1'b1;
        @(posedge clk);
        acc_cyc = ncyc;
        #1;
        u8_if.newd = 1'b0;
        check_eq("tx_low_after_accept", u8_if.tx, 1'b0);
        check_eq("busytx_after_accept", u8_if.busytx, 1'b1);
        cap = '0;
        repeat (Half) @(negedge clk);
        for (int b = 0; b < 10 + P; b++) begin
            cap[b] = u8_if.tx;
            if (b < 9 + P) begin
                if (inject && b == 4) begin
                    u8_if.dintx = 8'h11;
                    u8_if.newd  = 1'b1;
                    @(negedge clk);
                    u8_if.newd = 1'b0;
                    repeat (Bc - 1) @(negedge clk);
                end else begin
                    repeat (Bc) @(negedge clk);
                end
            end
        end
    endtask

    task automatic drive_rx8(input logic [7:0] d, input logic par, input logic stop);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (Bc) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            rx_drv = d[b];
            repeat (Bc) @(negedge clk);
        end
        if (P == 1) begin
            rx_drv = par;
            repeat (Bc) @(negedge clk);
        end
        rx_drv = stop;
        repeat (Bc) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * Bc) @(negedge clk);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, ptx, prx, b7, h7;
        logic [11:0] cap;

        u8_if.dintx = '0;
        u8_if.newd = 1'b0;
        u8_if.parity_odd = 1'b0;
        u7_if.dintx = '0;
        u7_if.newd = 1'b0;
        u7_if.parity_odd = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tx", u8_if.tx, 1'b1);
        check_eq("rst_busytx", u8_if.busytx, 1'b0);
        check_eq("rst_donetx", u8_if.donetx, 1'b0);
        check_eq("rst_doutrx", u8_if.doutrx, 8'h00);
        check_eq("rst_donerx", u8_if.donerx, 1'b0);
        check_eq("rst_frame_err", u8_if.frame_err, 1'b0);
        check_eq("rst_parity_err", u8_if.parity_err, 1'b0);
        check_eq("rst_tx7", u7_if.tx, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Loopback 0xA5, even parity when enabled.
        loop8 = 1'b1;
        ptx = tx8_done;
        prx = rx8_cnt;
        send8(8'hA5, 1'b0, acc, cap);
        check_eq("a5_line_bits", cap, frame8(8'hA5, 1'b0));
        wait_event(0, ptx, "a5_donetx_seen");
        check_eq("a5_donetx_latency", tx8_cyc - acc, 1 + F8);
        check_eq("a5_busytx_falls_with_done", u8_if.busytx, 1'b0);
        wait_event(1, prx, "a5_donerx_seen");
        check_eq("a5_donerx_latency", rx8_cyc - acc, 1 + RxLat8);
        check_eq("a5_doutrx", rx8_dout, 8'hA5);
        check_eq("a5_frame_err", rx8_ferr, 1'b0);
        check_eq("a5_parity_err", rx8_perr, 1'b0);
        check_eq("a5_doutrx_held", u8_if.doutrx, 8'hA5);
        repeat (2 * Bc) @(negedge clk);
        loop8 = 1'b0;

`ifdef UART_PARITY_EN
        prx = rx8_cnt;
        drive_rx8(8'hA5, 1'b1, 1'b1);
        wait_event(1, prx, "badpar_donerx_seen");
        check_eq("badpar_parity_err", rx8_perr, 1'b1);
        check_eq("badpar_doutrx", rx8_dout, 8'hA5);
        check_eq("badpar_frame_err", rx8_ferr, 1'b0);
`endif

        // Stop bit low, then a clean frame.
        prx = rx8_cnt;
        drive_rx8(8'h3C, ^8'h3C, 1'b0);
        wait_event(1, prx, "ferr_donerx_seen");
        check_eq("ferr_doutrx", rx8_dout, 8'h3C);
        check_eq("ferr_frame_err", rx8_ferr, 1'b1);
        check_eq("ferr_parity_err", rx8_perr, 1'b0);
        prx = rx8_cnt;
        drive_rx8(8'h55, ^8'h55, 1'b1);
        wait_event(1, prx, "clean55_donerx_seen");
        check_eq("clean55_doutrx", rx8_dout, 8'h55);
        check_eq("clean55_frame_err", rx8_ferr, 1'b0);

        // Short low glitch must not start a frame.
        prx = rx8_cnt;
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (20) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * Bc) @(negedge clk);
        check_eq("glitch_no_donerx", rx8_cnt, prx);
        drive_rx8(8'h96, ^8'h96, 1'b1);
        wait_event(1, prx, "after_glitch_donerx_seen");
        check_eq("after_glitch_doutrx", rx8_dout, 8'h96);

        // newd while busy, and newd in the donetx cycle, are both ignored.
        loop8 = 1'b1;
        repeat (Bc) @(negedge clk);
        ptx = tx8_done;
        prx = rx8_cnt;
        send8(8'hFF, 1'b1, acc, cap);
        check_eq("ff_line_bits", cap, frame8(8'hFF, 1'b0));
        wait_event(0, ptx, "ff_donetx_seen");
        u8_if.dintx = 8'h11;
        u8_if.newd  = 1'b1;
        @(posedge clk);
        #1;
        u8_if.newd = 1'b0;
        check_eq("newd_in_done_cycle_busytx", u8_if.busytx, 1'b0);
        check_eq("newd_in_done_cycle_tx", u8_if.tx, 1'b1);
        repeat (3 * Bc) @(negedge clk);
        check_eq("ff_single_donetx", tx8_done, ptx + 1);
        check_eq("ff_single_donerx", rx8_cnt, prx + 1);
        check_eq("ff_doutrx", rx8_dout, 8'hFF);

        // Reset in the middle of a TX and an RX frame.
        ptx = tx8_done;
        prx = rx8_cnt;
        @(negedge clk);
        u8_if.dintx = 8'h5A;
        u8_if.newd  = 1'b1;
        @(posedge clk);
        #1;
        u8_if.newd = 1'b0;
        repeat (300) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst_tx", u8_if.tx, 1'b1);
        check_eq("midrst_busytx", u8_if.busytx, 1'b0);
        check_eq("midrst_donetx", u8_if.donetx, 1'b0);
        check_eq("midrst_doutrx", u8_if.doutrx, 8'h00);
        check_eq("midrst_donerx", u8_if.donerx, 1'b0);
        check_eq("midrst_frame_err", u8_if.frame_err, 1'b0);
        check_eq("midrst_parity_err", u8_if.parity_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (1300) @(negedge clk);
        check_eq("midrst_no_donetx", tx8_done, ptx);
        check_eq("midrst_no_donerx", rx8_cnt, prx);

        // 7 data bits, 2 stop bits, loopback.
        ptx = tx7_done;
        prx = rx7_cnt;
        @(negedge clk);
        b7 = busy7;
        h7 = high7;
        u7_if.dintx = 7'h7F;
        u7_if.newd  = 1'b1;
        @(posedge clk);
        acc = ncyc;
        #1;
        u7_if.newd = 1'b0;
        wait_event(2, ptx, "d7_donetx_seen");
        check_eq("d7_donetx_latency", tx7_cyc - acc, 1 + F7);
        check_eq("d7_busy_cycles", busy7 - b7, F7);
        check_eq("d7_high_cycles", high7 - h7, (7 + P + 2) * Bc);
        wait_event(3, prx, "d7_donerx_seen");
        check_eq("d7_doutrx", rx7_dout, 7'h7F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
